// File: rtl/adc_serial_responder.sv
// adc_serial_responder: 3-wire serial write target that deserialises 32-bit frames into a 16x16 register image.
module adc_serial_responder #(
  parameter logic [11:0] HEADER   = 12'h001,
  parameter logic [3:0]  DES_ADDR = 4'hF,
  parameter int          DES_BIT  = 7
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        InSclk,
  input  logic        InSdata,
  input  logic        InSelect,
  input  logic [3:0]  RdAddr,
  output logic [15:0] RdData,
  output logic        FrameValid,
  output logic        FrameError,
  output logic [3:0]  LastAddr,
  output logic [1:0]  LastError,
  output logic [15:0] FrameCount,
  output logic [7:0]  ErrorCount,
  output logic        DesEnabled
);
  typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} state_t;
  state_t      r_state, w_state_n;
  logic [2:0]  r_sclk, r_sel;
  logic [1:0]  r_sdata;
  logic [5:0]  r_cnt, w_cnt;
  logic [31:0] r_shift, w_shift;
  logic [15:0] r_regs [16];
  logic [15:0] r_rd, r_fcnt;
  logic [7:0]  r_ecnt;
  logic [3:0]  r_last_addr;
  logic [1:0]  r_last_err, w_code;
  logic        r_fv, r_fe;
  logic        w_rise, w_sel_fall, w_sel_rise, w_start, w_take, w_over, w_end, w_ok, w_err;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sclk  <= 3'b000;
      r_sdata <= 2'b00;
      r_sel   <= 3'b111;
    end else begin
      r_sclk  <= {r_sclk[1:0], InSclk};
      r_sdata <= {r_sdata[0], InSdata};
      r_sel   <= {r_sel[1:0], InSelect};
    end
  end
  assign w_rise     = r_sclk[1] & ~r_sclk[2];
  assign w_sel_fall = ~r_sel[1] & r_sel[2];
  assign w_sel_rise = r_sel[1] & ~r_sel[2];
  // A same-cycle Sclk rise is folded into the count before the frame is judged.
  assign w_start = Enable && r_state == IDLE && w_sel_fall;
  assign w_take  = Enable && r_state == SHIFT && w_rise && r_cnt != 6'd32;
  assign w_over  = r_state == OVERRUN || (r_state == SHIFT && w_rise && r_cnt == 6'd32);
  assign w_cnt   = r_cnt + {5'd0, w_take};
  assign w_shift = w_take ? {r_shift[30:0], r_sdata[1]} : r_shift;
  assign w_end   = Enable && r_state != IDLE && w_sel_rise;
  assign w_ok    = w_end && !w_over && w_cnt == 6'd32 && w_shift[31:20] == HEADER;
  assign w_err   = w_end && !w_ok;
  assign w_code  = w_over ? 2'd2 : w_cnt != 6'd32 ? 2'd1 : 2'd3;
  always_comb begin
    w_state_n = r_state;
    if (!Enable) w_state_n = IDLE;
    else if (r_state == IDLE) w_state_n = w_sel_fall ? SHIFT : IDLE;
    else if (w_sel_rise) w_state_n = IDLE;
    else if (w_over) w_state_n = OVERRUN;
  end
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= IDLE;
    else r_state <= w_state_n;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rd        <= '0;
      r_fcnt      <= '0;
      r_ecnt      <= '0;
      r_last_addr <= '0;
      r_last_err  <= '0;
      r_fv        <= 1'b0;
      r_fe        <= 1'b0;
    end else begin
      r_fv <= w_ok;
      r_fe <= w_err;
      r_rd <= r_regs[RdAddr];
      if (w_start) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_take) begin
        r_cnt   <= w_cnt;
        r_shift <= w_shift;
      end
      if (w_ok) begin
        r_regs[w_shift[19:16]] <= w_shift[15:0];
        r_last_addr            <= w_shift[19:16];
        r_last_err             <= 2'd0;
        r_fcnt                 <= r_fcnt + {15'd0, r_fcnt != 16'hFFFF};
      end
      if (w_err) begin
        r_last_err <= w_code;
        r_ecnt     <= r_ecnt + {7'd0, r_ecnt != 8'hFF};
      end
    end
  end
  assign RdData     = r_rd;
  assign FrameValid = r_fv;
  assign FrameError = r_fe;
  assign LastAddr   = r_last_addr;
  assign LastError  = r_last_err;
  assign FrameCount = r_fcnt;
  assign ErrorCount = r_ecnt;
  assign DesEnabled = r_regs[DES_ADDR][DES_BIT];
endmodule

// File: tb/tb_adc_serial_responder.sv
// tb_adc_serial_responder: random and directed frames checked against a frame-level reference model via a scoreboard.
module tb_adc_serial_responder;
  logic        Clock = 1'b0, Reset = 1'b1, Enable = 1'b1;
  logic        InSclk = 1'b0, InSdata = 1'b0, InSelect = 1'b1;
  logic [3:0]  RdAddr = '0;
  logic [15:0] RdData, FrameCount;
  logic        FrameValid, FrameError, DesEnabled;
  logic [3:0]  LastAddr;
  logic [1:0]  LastError;
  logic [7:0]  ErrorCount;
  typedef struct {
    bit          ok;
    logic [3:0]  addr;
    logic [1:0]  code;
    logic [15:0] fc;
    logic [7:0]  ec;
    bit          des;
  } exp_t;
  exp_t        sb[$];
  logic [15:0] m_regs [16];
  logic [15:0] m_fc;
  logic [7:0]  m_ec;
  logic [3:0]  m_addr;
  logic [1:0]  m_err;
  int          vectors = 0, miscompares = 0;
  adc_serial_responder dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .InSclk(InSclk), .InSdata(InSdata),
    .InSelect(InSelect), .RdAddr(RdAddr), .RdData(RdData), .FrameValid(FrameValid),
    .FrameError(FrameError), .LastAddr(LastAddr), .LastError(LastError),
    .FrameCount(FrameCount), .ErrorCount(ErrorCount), .DesEnabled(DesEnabled)
  );
  always #5 Clock = ~Clock;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_fc = '0; m_ec = '0; m_addr = '0; m_err = '0;
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask
  // Frame outcome from its bit count and content alone.
  task automatic predict(input logic [31:0] v, input int n);
    exp_t e;
    e.ok = 1'b0;
    e.code = n < 32 ? 2'd1 : n > 32 ? 2'd2 : v[31:20] != 12'h001 ? 2'd3 : 2'd0;
    if (e.code == 2'd0) begin
      e.ok = 1'b1;
      m_regs[v[19:16]] = v[15:0];
      m_addr = v[19:16];
      if (m_fc != 16'hFFFF) m_fc++;
    end else if (m_ec != 8'hFF) m_ec++;
    m_err = e.code;
    e.addr = m_addr; e.fc = m_fc; e.ec = m_ec; e.des = m_regs[15][7];
    sb.push_back(e);
  endtask
  task automatic shift_bits(input logic [31:0] v, input int n);
    InSelect = 1'b0;
    wait_cyc(3);
    for (int k = 0; k < n; k++) begin
      InSdata = k < 32 ? v[31-k] : 1'($urandom_range(1, 0));
      wait_cyc(4);
      InSclk = 1'b1;
      wait_cyc(4);
      InSclk = 1'b0;
    end
    wait_cyc(2);
  endtask
  task automatic send(input logic [31:0] v, input int n);
    shift_bits(v, n);
    predict(v, n);
    InSelect = 1'b1;
    wait_cyc(6);
  endtask
  task automatic check_regs();
    for (int a = 0; a < 16; a++) begin
      @(negedge Clock);
      RdAddr = 4'(a);
      @(negedge Clock);
      chk($sformatf("rd%0d", a), RdData, m_regs[a]);
    end
  endtask
  task automatic check_status(input string tag);
    chk({tag, "_fc"}, FrameCount, m_fc);
    chk({tag, "_ec"}, ErrorCount, m_ec);
    chk({tag, "_le"}, LastError, m_err);
    chk({tag, "_la"}, LastAddr, m_addr);
    chk({tag, "_des"}, DesEnabled, m_regs[15][7]);
  endtask
  always @(negedge Clock) begin
    if (!Reset && (FrameValid || FrameError)) begin
      if (sb.size() == 0) chk("unexpected_pulse", {FrameValid, FrameError}, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse", {FrameValid, FrameError}, e.ok ? 2 : 1);
        chk("last_addr", LastAddr, e.addr);
        chk("last_err", LastError, e.code);
        chk("frame_cnt", FrameCount, e.fc);
        chk("err_cnt", ErrorCount, e.ec);
        chk("des", DesEnabled, e.des);
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] v;
    int n, r;
    model_reset();
    wait_cyc(4);
    Reset = 1'b0;
    wait_cyc(2);
    check_status("rst");
    chk("rst_rd", RdData, 0);
    send(32'h001F_0080, 32);
    check_status("des_on");
    send(32'h001F_0000, 32);
    check_status("des_off");
    check_regs();
    send(32'h0013_ABCD, 32);
    send(32'h0012_3456, 20);
    check_status("short");
    send(32'h0014_1111, 33);
    check_status("long");
    send(32'h0025_2222, 32);
    check_status("hdr");
    check_regs();
    shift_bits(32'h0016_BEEF, 16);
    Reset = 1'b1;
    InSelect = 1'b1;
    wait_cyc(3);
    Reset = 1'b0;
    model_reset();
    wait_cyc(3);
    check_status("midrst");
    send(32'h0016_BEEF, 32);
    check_status("resend");
    check_regs();
    shift_bits(32'h0017_7777, 10);
    Enable = 1'b0;
    wait_cyc(2);
    InSelect = 1'b1;
    wait_cyc(6);
    Enable = 1'b1;
    wait_cyc(4);
    check_status("en_drop");
    for (int k = 0; k < 6; k++) begin
      InSdata = 1'($urandom_range(1, 0));
      InSclk = ~InSclk;
      wait_cyc(3);
    end
    InSclk = 1'b0;
    wait_cyc(4);
    check_status("idle_sclk");
    for (int t = 0; t < 60; t++) begin
      v = $urandom;
      v[31:20] = 12'h001;
      n = 32;
      r = $urandom_range(0, 9);
      if (r == 0) n = $urandom_range(1, 31);
      else if (r == 1) n = $urandom_range(33, 35);
      else if (r == 2) v[31:20] = 12'($urandom_range(2, 4095));
      send(v, n);
    end
    check_regs();
    for (int t = 0; t < 300; t++) send($urandom, 1);
    check_status("sat");
    chk("sat_ec", ErrorCount, 8'hFF);
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge Clock);
    chk("drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
